dwt_pair_framer: RTL and testbench
==================================

Name: dwt_pair_framer

Overview:
- Sequencer at the input of the 1D DWT lifting processing unit (column or row).
- Takes a raster stream of single samples for one W x H tile and packs it into (even, odd) sample pairs.
- Generates the sof/eol framing the lifting unit relies on to reset its line buffers and counters.
- Controlled per tile by a start/busy/done handshake; validates tile geometry and the source line markers.

Parameters:
DataWidth, 16, sample width in bits (signed fixed point, passed through unchanged)
MaximumSideSize, 512, maximum tile width and height in samples
CntWidth, $clog2(MaximumSideSize)+1, width of cfg_width_i/cfg_height_i (derived, do not override)

Ports:
clk_i  in  1  clock; all logic on rising edge
rst_ni  in  1  asynchronous active-low reset
cfg_width_i  in  CntWidth  tile width in samples; sampled on accepted start
cfg_height_i  in  CntWidth  tile height in lines; sampled on accepted start
start_i  in  1  start one tile; honoured only in IDLE
busy_o  out  1  high from accepted start until done_o
done_o  out  1  one-cycle pulse when the last pair leaves the output register
err_o  out  1  one-cycle pulse: rejected config or s_last_i mismatch
s_ready_o  out  1  sample stream ready
s_valid_i  in  1  sample stream valid
s_last_i  in  1  source end-of-line marker
s_data_i  in  DataWidth  sample
m_ready_i  in  1  pair stream ready (from processing unit)
m_valid_o  out  1  pair stream valid
m_sof_o  out  1  first pair of tile
m_eol_o  out  1  last pair of a line
m_data_even_o  out  DataWidth  even-index sample (column 2k)
m_data_odd_o  out  DataWidth  odd-index sample (column 2k+1)

Behaviour:
- Reset (rst_ni low, any time, including mid-tile):
  - State to IDLE; all outputs 0; output register emptied; counters and phase cleared.
  - Partial tile discarded.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - s_ready_o=0.
  - Config is valid when width is even, 2 <= width <= MaximumSideSize, and 1 <= height <= MaximumSideSize.
  - start_i=1 with valid config: latch width/2 (pairs per line) and height, clear col/row/phase, set busy_o next cycle, go to RUN.
  - start_i=1 with invalid config: err_o pulse next cycle, stay IDLE.
- RUN, phase 0 (even sample):
  - s_ready_o=1.
  - Accepted sample goes to the even holding register; phase toggles to 1.
- RUN, phase 1 (odd sample):
  - s_ready_o = !out_full || m_ready_i.
  - On accept, the pair {hold, s_data_i} loads the output register with sof=(row==0 && col==0) and eol=(col==pairs-1).
  - Phase toggles to 0; col increments, wrapping to 0 at eol, where row increments.
- Latency: pair valid on m_valid_o the cycle after its odd sample is accepted.
- Throughput: one pair per two input samples; no bubbles under continuous valid/ready.
- Output register: single entry.
  - Holds data and flags stable while m_valid_o=1 && m_ready_i=0.
  - Load and drain in the same cycle are allowed (full throughput).
- s_last_i check, both directions:
  - Expected high exactly on the odd sample of each line end.
  - High at any other sample, or low at line end, gives an err_o pulse the cycle after the accept.
  - Counters stay authoritative; data is not dropped.
- When the pair with row==height-1, col==pairs-1 is loaded: go to DRAIN; s_ready_o=0.
- DRAIN: when the output register drains (m_ready_i=1), done_o pulses in that same drain cycle's following edge; busy_o drops with it; go to IDLE.
- start_i while busy_o=1 is ignored; no error.
- Config input changes after start have no effect until the next start.
- Minimum tile 2x1: one pair carrying both m_sof_o=1 and m_eol_o=1.
- Counter wrap at MaximumSideSize must not overflow CntWidth.

Test Plan:
- Reset, then start with width=4, height=2 and samples 1..8 with correct s_last_i:
  - Pairs (1,2)sof, (3,4)eol, (5,6), (7,8)eol.
  - done_o pulses once after (7,8) is accepted; err_o stays 0.
- Config rejection: start with width=5 and, separately, width=0 and height=MaximumSideSize+1 -> err_o pulses, busy_o stays 0, s_ready_o stays 0.
- Backpressure: width=8, height=1, m_ready_i toggled 1,0,0,1 -> data and flags stable while stalled; no lost or duplicated pairs; continuous ready gives 1 pair per 2 samples.
- Marker mismatch: width=4, s_last_i high on sample 2 and missing on sample 4 -> two err_o pulses; output pairs and eol positions unchanged.
- Reset mid-tile: assert rst_ni low after 3 samples -> outputs 0 immediately; a new start with width=2, height=1 yields a single pair with sof=eol=1, then done_o.
- Max size: width=height=MaximumSideSize with random valid/ready -> exactly 131072 pairs, 512 eol, 1 sof, 1 done_o.

Source files
------------

// File: rtl/dwt_pair_framer.sv
// Input sequencer for the 1D DWT lifting unit: packs a raster sample stream of
// one W x H tile into (even, odd) pairs with sof/eol framing and checks source markers.
module dwt_pair_framer #(
  parameter int DataWidth       = 16,
  parameter int MaximumSideSize = 512,
  parameter int CntWidth        = $clog2(MaximumSideSize) + 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [CntWidth-1:0]  cfg_width_i,
  input  logic [CntWidth-1:0]  cfg_height_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 s_ready_o,
  input  logic                 s_valid_i,
  input  logic                 s_last_i,
  input  logic [DataWidth-1:0] s_data_i,
  input  logic                 m_ready_i,
  output logic                 m_valid_o,
  output logic                 m_sof_o,
  output logic                 m_eol_o,
  output logic [DataWidth-1:0] m_data_even_o,
  output logic [DataWidth-1:0] m_data_odd_o
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;

  localparam logic [CntWidth-1:0] CntZero = '0;
  localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);
  localparam logic [CntWidth-1:0] CntTwo  = CntWidth'(2);
  localparam logic [CntWidth-1:0] CntMax  = CntWidth'(MaximumSideSize);

  logic [1:0]           state_reg;
  logic                 phase_reg;
  logic [CntWidth-1:0]  col_reg;
  logic [CntWidth-1:0]  row_reg;
  logic [CntWidth-1:0]  pairs_reg;
  logic [CntWidth-1:0]  height_reg;
  logic [DataWidth-1:0] hold_reg;
  logic                 busy_reg;
  logic                 done_reg;
  logic                 err_reg;

  logic                 out_full_reg;
  logic                 out_sof_reg;
  logic                 out_eol_reg;
  logic [DataWidth-1:0] out_even_reg;
  logic [DataWidth-1:0] out_odd_reg;

  logic cfg_ok;
  logic s_accept;
  logic odd_accept;
  logic line_end;
  logic last_row;
  logic last_expected;
  logic out_drain;

  assign cfg_ok = !cfg_width_i[0] &&
                  (cfg_width_i >= CntTwo) && (cfg_width_i <= CntMax) &&
                  (cfg_height_i != CntZero) && (cfg_height_i <= CntMax);

  // The even sample only fills the holding register, so it never waits on the sink.
  assign s_ready_o = (state_reg == StRun) && (!phase_reg || !out_full_reg || m_ready_i);

  assign s_accept      = s_valid_i && s_ready_o;
  assign odd_accept    = s_accept && phase_reg;
  assign line_end      = (col_reg == pairs_reg - CntOne);
  assign last_row      = (row_reg == height_reg - CntOne);
  assign last_expected = phase_reg && line_end;
  assign out_drain     = out_full_reg && m_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= StIdle;
      phase_reg  <= 1'b0;
      col_reg    <= '0;
      row_reg    <= '0;
      pairs_reg  <= '0;
      height_reg <= '0;
      hold_reg   <= '0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        StIdle: begin
          if (start_i) begin
            if (cfg_ok) begin
              pairs_reg  <= cfg_width_i >> 1;
              height_reg <= cfg_height_i;
              col_reg    <= '0;
              row_reg    <= '0;
              phase_reg  <= 1'b0;
              busy_reg   <= 1'b1;
              state_reg  <= StRun;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        StRun: begin
          if (s_accept) begin
            phase_reg <= !phase_reg;
            // Marker errors are reported but the counters keep the framing.
            if (s_last_i != last_expected) begin
              err_reg <= 1'b1;
            end
            if (!phase_reg) begin
              hold_reg <= s_data_i;
            end else if (line_end) begin
              col_reg <= '0;
              row_reg <= row_reg + CntOne;
              if (last_row) begin
                state_reg <= StDrain;
              end
            end else begin
              col_reg <= col_reg + CntOne;
            end
          end
        end
        StDrain: begin
          if (out_drain) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= StIdle;
          end
        end
        default: state_reg <= StIdle;
      endcase
    end
  end

  // Single-entry output register; a load may coincide with a drain.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_full_reg <= 1'b0;
      out_sof_reg  <= 1'b0;
      out_eol_reg  <= 1'b0;
      out_even_reg <= '0;
      out_odd_reg  <= '0;
    end else if (odd_accept) begin
      out_full_reg <= 1'b1;
      out_sof_reg  <= (row_reg == CntZero) && (col_reg == CntZero);
      out_eol_reg  <= line_end;
      out_even_reg <= hold_reg;
      out_odd_reg  <= s_data_i;
    end else if (out_drain) begin
      out_full_reg <= 1'b0;
    end
  end

  assign busy_o        = busy_reg;
  assign done_o        = done_reg;
  assign err_o         = err_reg;
  assign m_valid_o     = out_full_reg;
  assign m_sof_o       = out_full_reg && out_sof_reg;
  assign m_eol_o       = out_full_reg && out_eol_reg;
  assign m_data_even_o = out_even_reg;
  assign m_data_odd_o  = out_odd_reg;

endmodule

// File: tb/tb_dwt_pair_framer.sv
// Directed bench for dwt_pair_framer: tiles are fed from a sample queue and
// the pairs seen on the output handshake are checked against hand-built expectations.
module tb_dwt_pair_framer;

  localparam int DW  = 16;
  localparam int MAX = 64;
  localparam int CW  = $clog2(MAX) + 1;

  typedef struct packed {
    logic [DW-1:0] even;
    logic [DW-1:0] odd;
    logic          sof;
    logic          eol;
  } pair_t;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
  } smp_t;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] cfg_w;
  logic [CW-1:0] cfg_h;
  logic          start;
  logic          busy;
  logic          done;
  logic          err;
  logic          s_ready;
  logic          s_valid;
  logic          s_last;
  logic [DW-1:0] s_data;
  logic          m_ready;
  logic          m_valid;
  logic          m_sof;
  logic          m_eol;
  logic [DW-1:0] m_even;
  logic [DW-1:0] m_odd;

  int checks = 0;
  int passes = 0;

  pair_t got_q[$];
  smp_t  src_q[$];
  int    done_cnt   = 0;
  int    err_cnt    = 0;
  int    stall_viol = 0;
  logic  prev_stall = 1'b0;
  pair_t prev_pair;
  pair_t cur_pair;

  dwt_pair_framer #(
    .DataWidth       (DW),
    .MaximumSideSize (MAX)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .cfg_width_i   (cfg_w),
    .cfg_height_i  (cfg_h),
    .start_i       (start),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err),
    .s_ready_o     (s_ready),
    .s_valid_i     (s_valid),
    .s_last_i      (s_last),
    .s_data_i      (s_data),
    .m_ready_i     (m_ready),
    .m_valid_o     (m_valid),
    .m_sof_o       (m_sof),
    .m_eol_o       (m_eol),
    .m_data_even_o (m_even),
    .m_data_odd_o  (m_odd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign cur_pair = '{m_even, m_odd, m_sof, m_eol};

  // Output monitor: records handshakes, counts pulses, watches stall stability.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_valid && m_ready) got_q.push_back(cur_pair);
      if (done) done_cnt <= done_cnt + 1;
      if (err) err_cnt <= err_cnt + 1;
      if (prev_stall && (!m_valid || cur_pair != prev_pair)) stall_viol <= stall_viol + 1;
      prev_stall <= m_valid && !m_ready;
      prev_pair  <= cur_pair;
    end else begin
      prev_stall <= 1'b0;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_last = 1'b0;
    s_data = '0; m_ready = 1'b0; cfg_w = '0; cfg_h = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int w, input int h);
    cfg_w = CW'(w); cfg_h = CW'(h); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic push_sample(input int d, input bit l);
    src_q.push_back('{DW'(d), l});
  endtask

  // Feeds src_q until done_o is seen. rmode: 0 ready always, 1 pattern 1,0,0,1, 2 random.
  task automatic run_tile(input int max_cyc, input bit rand_valid, input int rmode,
                          output bit timed_out, output int src_stall);
    timed_out = 1'b1;
    src_stall = 0;
    for (int cyc = 0; cyc < max_cyc; cyc++) begin
      s_valid = (src_q.size() > 0) && (!rand_valid || $urandom_range(3) != 0);
      if (src_q.size() > 0) begin
        s_data = src_q[0].d;
        s_last = src_q[0].l;
      end
      case (rmode)
        0:       m_ready = 1'b1;
        1:       m_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: m_ready = ($urandom_range(3) != 0);
      endcase
      @(negedge clk);
      if (s_valid && s_ready) void'(src_q.pop_front());
      else if (s_valid) src_stall++;
      if (done) begin
        timed_out = 1'b0;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passes++;
    checks++; if (s_ready !== 1'b0) $display("FAIL reset_s_ready: got %b want 0", s_ready); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL reset_m_valid: got %b want 0", m_valid); else passes++;
    checks++; if ({m_sof, m_eol, m_even, m_odd} !== '0)
      $display("FAIL reset_m_fields: got %h want 0", {m_sof, m_eol, m_even, m_odd}); else passes++;
    $display("reset: outputs checked");
  endtask

  task automatic test_basic();
    pair_t exp_p[4];
    int n0, d0, e0, ss;
    bit to;
    exp_p[0] = '{16'd1, 16'd2, 1'b1, 1'b0};
    exp_p[1] = '{16'd3, 16'd4, 1'b0, 1'b1};
    exp_p[2] = '{16'd5, 16'd6, 1'b0, 1'b0};
    exp_p[3] = '{16'd7, 16'd8, 1'b0, 1'b1};
    n0 = got_q.size(); d0 = done_cnt; e0 = err_cnt;
    do_start(4, 2);
    // A start with a bad config while busy must be ignored, as must the config change.
    cfg_w = CW'(5); cfg_h = '0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else passes++;
    for (int i = 1; i <= 8; i++) push_sample(i, (i == 4) || (i == 8));
    run_tile(200, 1'b0, 0, to, ss);
    checks++; if (to !== 1'b0) $display("FAIL basic_timeout: got %b want 0", to); else passes++;
    checks++; if (got_q.size() - n0 != 4) $display("FAIL basic_count: got %0d want 4", got_q.size() - n0); else passes++;
    for (int i = 0; i < 4; i++) begin
      if (n0 + i < got_q.size()) begin
        checks++;
        if (got_q[n0+i] !== exp_p[i]) $display("FAIL basic_pair%0d: got %h want %h", i, got_q[n0+i], exp_p[i]);
        else passes++;
      end
    end
    checks++; if (done_cnt - d0 != 1) $display("FAIL basic_done: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (err_cnt - e0 != 0) $display("FAIL basic_err: got %0d want 0", err_cnt - e0); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else passes++;
    $display("basic tile 4x2: %0d pairs, %0d done", got_q.size() - n0, done_cnt - d0);
  endtask

  task automatic test_config_reject();
    int ws[4] = '{5, 0, 4, MAX + 2};
    int hs[4] = '{2, 2, MAX + 1, 1};
    for (int k = 0; k < 4; k++) begin
      do_start(ws[k], hs[k]);
      checks++; if (err !== 1'b1) $display("FAIL reject%0d_err: got %b want 1", k, err); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reject%0d_busy: got %b want 0", k, busy); else passes++;
      checks++; if (s_ready !== 1'b0) $display("FAIL reject%0d_s_ready: got %b want 0", k, s_ready); else passes++;
      @(posedge clk); #1;
      checks++; if (err !== 1'b0) $display("FAIL reject%0d_err_pulse: got %b want 0", k, err); else passes++;
      checks++; if (busy !== 1'b0) $display("FAIL reject%0d_busy2: got %b want 0", k, busy); else passes++;
      $display("reject config w=%0d h=%0d", ws[k], hs[k]);
    end
  endtask

  task automatic test_backpressure();
    pair_t exp_p[4];
    int n0, d0, v0, ss;
    bit to;
    exp_p[0] = '{16'd10, 16'd11, 1'b1, 1'b0};
    exp_p[1] = '{16'd12, 16'd13, 1'b0, 1'b0};
    exp_p[2] = '{16'd14, 16'd15, 1'b0, 1'b0};
    exp_p[3] = '{16'd16, 16'd17, 1'b0, 1'b1};
    n0 = got_q.size(); d0 = done_cnt; v0 = stall_viol;
    do_start(8, 1);
    for (int i = 0; i < 8; i++) push_sample(10 + i, i == 7);
    run_tile(200, 1'b0, 1, to, ss);
    checks++; if (to !== 1'b0) $display("FAIL bp_timeout: got %b want 0", to); else passes++;
    checks++; if (got_q.size() - n0 != 4) $display("FAIL bp_count: got %0d want 4", got_q.size() - n0); else passes++;
    for (int i = 0; i < 4; i++) begin
      if (n0 + i < got_q.size()) begin
        checks++;
        if (got_q[n0+i] !== exp_p[i]) $display("FAIL bp_pair%0d: got %h want %h", i, got_q[n0+i], exp_p[i]);
        else passes++;
      end
    end
    checks++; if (stall_viol - v0 != 0) $display("FAIL bp_stable: got %0d changes want 0", stall_viol - v0); else passes++;
    checks++; if (done_cnt - d0 != 1) $display("FAIL bp_done: got %0d want 1", done_cnt - d0); else passes++;
    $display("backpressure tile 8x1: %0d pairs", got_q.size() - n0);
    n0 = got_q.size();
    do_start(8, 1);
    for (int i = 0; i < 8; i++) push_sample(10 + i, i == 7);
    run_tile(200, 1'b0, 0, to, ss);
    checks++; if (ss != 0) $display("FAIL bp_full_rate: got %0d source stalls want 0", ss); else passes++;
    checks++; if (got_q.size() - n0 != 4) $display("FAIL bp_full_count: got %0d want 4", got_q.size() - n0); else passes++;
    $display("full-rate tile 8x1: %0d pairs, %0d stalls", got_q.size() - n0, ss);
  endtask

  task automatic test_marker_mismatch();
    pair_t exp_p[2];
    int n0, e0, ss;
    bit to;
    exp_p[0] = '{16'd1, 16'd2, 1'b1, 1'b0};
    exp_p[1] = '{16'd3, 16'd4, 1'b0, 1'b1};
    n0 = got_q.size(); e0 = err_cnt;
    do_start(4, 1);
    push_sample(1, 1'b0); push_sample(2, 1'b1); push_sample(3, 1'b0); push_sample(4, 1'b0);
    run_tile(200, 1'b0, 0, to, ss);
    checks++; if (err_cnt - e0 != 2) $display("FAIL marker_err: got %0d want 2", err_cnt - e0); else passes++;
    checks++; if (got_q.size() - n0 != 2) $display("FAIL marker_count: got %0d want 2", got_q.size() - n0); else passes++;
    for (int i = 0; i < 2; i++) begin
      if (n0 + i < got_q.size()) begin
        checks++;
        if (got_q[n0+i] !== exp_p[i]) $display("FAIL marker_pair%0d: got %h want %h", i, got_q[n0+i], exp_p[i]);
        else passes++;
      end
    end
    $display("marker tile 4x1: %0d errors", err_cnt - e0);
  endtask

  task automatic test_reset_mid_tile();
    do_start(4, 2);
    s_valid = 1'b1; s_last = 1'b0; m_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      s_data = DW'(i);
      @(posedge clk); #1;
    end
    checks++; if (m_valid !== 1'b1) $display("FAIL midrst_pre_valid: got %b want 1", m_valid); else passes++;
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", m_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", busy); else passes++;
    checks++; if (s_ready !== 1'b0) $display("FAIL midrst_s_ready: got %b want 0", s_ready); else passes++;
    checks++; if ({m_sof, m_eol, m_even, m_odd} !== '0)
      $display("FAIL midrst_fields: got %h want 0", {m_sof, m_eol, m_even, m_odd}); else passes++;
    s_valid = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_start(2, 1);
    s_valid = 1'b1; s_data = 16'h00aa; s_last = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b0) $display("FAIL min_early_valid: got %b want 0", m_valid); else passes++;
    s_data = 16'h0055; s_last = 1'b1;
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    checks++; if (m_valid !== 1'b1) $display("FAIL min_valid: got %b want 1", m_valid); else passes++;
    checks++; if ({m_even, m_odd, m_sof, m_eol} !== {16'h00aa, 16'h0055, 1'b1, 1'b1})
      $display("FAIL min_pair: got %h want %h", {m_even, m_odd, m_sof, m_eol}, {16'h00aa, 16'h0055, 1'b1, 1'b1});
    else passes++;
    checks++; if (s_ready !== 1'b0) $display("FAIL min_drain_ready: got %b want 0", s_ready); else passes++;
    checks++; if (done !== 1'b0) $display("FAIL min_early_done: got %b want 0", done); else passes++;
    m_ready = 1'b1;
    @(posedge clk); #1;
    m_ready = 1'b0;
    checks++; if (done !== 1'b1) $display("FAIL min_done: got %b want 1", done); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL min_busy: got %b want 0", busy); else passes++;
    checks++; if (m_valid !== 1'b0) $display("FAIL min_drained: got %b want 0", m_valid); else passes++;
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) $display("FAIL min_done_pulse: got %b want 0", done); else passes++;
    $display("reset mid-tile then 2x1 tile");
  endtask

  task automatic test_max_size();
    int n0, d0, e0, ss, npairs, neol, nsof, bad;
    bit to;
    pair_t p;
    n0 = got_q.size(); d0 = done_cnt; e0 = err_cnt;
    do_start(MAX, MAX);
    for (int r = 0; r < MAX; r++)
      for (int c = 0; c < MAX; c++) push_sample(r * MAX + c, c == MAX - 1);
    run_tile(30000, 1'b1, 2, to, ss);
    npairs = got_q.size() - n0; neol = 0; nsof = 0; bad = 0;
    for (int k = 0; k < npairs; k++) begin
      p = got_q[n0+k];
      if (p.eol) neol++;
      if (p.sof) nsof++;
      if (p.even !== DW'(2 * k) || p.odd !== DW'(2 * k + 1) ||
          p.sof !== (k == 0) || p.eol !== (k % (MAX / 2) == MAX / 2 - 1)) bad++;
    end
    checks++; if (to !== 1'b0) $display("FAIL max_timeout: got %b want 0", to); else passes++;
    checks++; if (npairs != MAX * MAX / 2) $display("FAIL max_pairs: got %0d want %0d", npairs, MAX * MAX / 2); else passes++;
    checks++; if (neol != MAX) $display("FAIL max_eol: got %0d want %0d", neol, MAX); else passes++;
    checks++; if (nsof != 1) $display("FAIL max_sof: got %0d want 1", nsof); else passes++;
    checks++; if (bad != 0) $display("FAIL max_content: got %0d wrong pairs want 0", bad); else passes++;
    checks++; if (done_cnt - d0 != 1) $display("FAIL max_done: got %0d want 1", done_cnt - d0); else passes++;
    checks++; if (err_cnt - e0 != 0) $display("FAIL max_err: got %0d want 0", err_cnt - e0); else passes++;
    $display("max tile %0dx%0d: %0d pairs, %0d eol, %0d sof", MAX, MAX, npairs, neol, nsof);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_config_reject();
    test_backpressure();
    test_marker_mismatch();
    test_reset_mid_tile();
    test_max_size();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
